// File: rtl/cnn_rd_arbiter_if.sv
// cnn_rd_arbiter_if: requester-side and shared-port read handshakes of the DMA read arbiter
interface cnn_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] m0_ar_addr, m1_ar_addr, s_ar_addr;
    logic              m0_ar_en, m1_ar_en, m0_ar_get, m1_ar_get;
    logic              m0_r_ready, m1_r_ready, m0_r_valid, m1_r_valid, m0_r_end, m1_r_end;
    logic [DATA_W-1:0] m0_r_data, m1_r_data, s_r_data;
    logic              s_ar_en, s_ar_get, s_r_ready, s_r_valid, s_r_end;

    modport slave (
        input  m0_ar_addr, m1_ar_addr, m0_ar_en, m1_ar_en, m0_r_ready, m1_r_ready,
        input  s_ar_get, s_r_valid, s_r_end, s_r_data,
        output m0_ar_get, m1_ar_get, m0_r_valid, m1_r_valid, m0_r_end, m1_r_end,
        output m0_r_data, m1_r_data, s_ar_addr, s_ar_en, s_r_ready
    );
    modport master (
        output m0_ar_addr, m1_ar_addr, m0_ar_en, m1_ar_en, m0_r_ready, m1_r_ready,
        output s_ar_get, s_r_valid, s_r_end, s_r_data,
        input  m0_ar_get, m1_ar_get, m0_r_valid, m1_r_valid, m0_r_end, m1_r_end,
        input  m0_r_data, m1_r_data, s_ar_addr, s_ar_en, s_r_ready
    );
endinterface

// File: rtl/cnn_rd_arbiter.sv
// cnn_rd_arbiter: round-robin sharing of one AXI read path between feature-map (m0) and weight (m1) DMA readers
module cnn_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    cnn_rd_arbiter_if.slave   bus,
    input  logic              cnt_clr,
    output logic [1:0]        grant,
    output logic              busy,
    output logic [CNT_W-1:0]  m0_burst_cnt,
    output logic [CNT_W-1:0]  m1_burst_cnt
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t state, state_n;
    logic last_owner, sel, req, owner, done, in_addr, in_data;
    logic [ADDR_W-1:0] sel_addr;

    assign req      = bus.m0_ar_en | bus.m1_ar_en;
    assign sel      = (bus.m0_ar_en & bus.m1_ar_en) ? ~last_owner : bus.m1_ar_en;
    assign sel_addr = sel ? bus.m1_ar_addr : bus.m0_ar_addr;
    assign owner    = grant[1];
    assign in_addr  = state == ADDR;
    assign in_data  = state == DATA;
    assign done     = in_data & bus.s_r_valid & bus.s_r_ready & bus.s_r_end;
    assign busy     = state != IDLE;

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = req ? ADDR : IDLE;
            ADDR:    state_n = bus.s_ar_get ? DATA : ADDR;
            DATA:    state_n = done ? IDLE : DATA;
            default: state_n = IDLE;
        endcase
    end

    // owner is latched in grant at request time and held until the burst's last beat
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            bus.s_ar_en   <= 1'b0;
            bus.s_ar_addr <= '0;
            grant         <= '0;
            last_owner    <= 1'b1;
        end else if (state == IDLE && req) begin
            bus.s_ar_en   <= 1'b1;
            bus.s_ar_addr <= sel_addr;
            grant         <= sel ? 2'b10 : 2'b01;
        end else if (in_addr && bus.s_ar_get) begin
            bus.s_ar_en <= 1'b0;
        end else if (done) begin
            last_owner <= owner;
            grant      <= '0;
        end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            m0_burst_cnt <= '0;
            m1_burst_cnt <= '0;
        end else if (cnt_clr) begin
            m0_burst_cnt <= '0;
            m1_burst_cnt <= '0;
        end else if (done) begin
            if (owner) m1_burst_cnt <= m1_burst_cnt + 1'b1;
            else m0_burst_cnt <= m0_burst_cnt + 1'b1;
        end

    always_comb begin
        bus.m0_ar_get  = in_addr & bus.s_ar_get & ~owner;
        bus.m1_ar_get  = in_addr & bus.s_ar_get & owner;
        bus.s_r_ready  = in_data & (owner ? bus.m1_r_ready : bus.m0_r_ready);
        bus.m0_r_valid = in_data & ~owner & bus.s_r_valid;
        bus.m1_r_valid = in_data & owner & bus.s_r_valid;
        bus.m0_r_end   = in_data & ~owner & bus.s_r_end;
        bus.m1_r_end   = in_data & owner & bus.s_r_end;
        bus.m0_r_data  = (in_data && !owner) ? bus.s_r_data : {DATA_W{1'b0}};
        bus.m1_r_data  = (in_data && owner) ? bus.s_r_data : {DATA_W{1'b0}};
    end
endmodule

// File: tb/tb_cnn_rd_arbiter.sv
// tb_cnn_rd_arbiter: directed bench with address/beat scoreboards and a round-robin reference model
module tb_cnn_rd_arbiter;
    localparam int CNT_W = 4;
    logic clk = 1'b0, rstn = 1'b0, cnt_clr = 1'b0;
    logic [1:0] grant;
    logic busy;
    logic [CNT_W-1:0] m0_burst_cnt, m1_burst_cnt;
    int checks = 0, errors = 0, rem0 = 0, rem1 = 0;
    logic m_last = 1'b1;
    logic [CNT_W-1:0] c0 = '0, c1 = '0;
    logic [32:0] aq[$];
    logic [64:0] q0[$], q1[$];
    logic [63:0] d;

    cnn_rd_arbiter_if #(.ADDR_W(32), .DATA_W(64)) ifc ();

    cnn_rd_arbiter #(.ADDR_W(32), .DATA_W(64), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .bus(ifc.slave), .cnt_clr(cnt_clr), .grant(grant),
        .busy(busy), .m0_burst_cnt(m0_burst_cnt), .m1_burst_cnt(m1_burst_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: address grants and delivered beats are compared as the DUT produces them
    always @(negedge clk) begin
        if (ifc.m0_ar_get || ifc.m1_ar_get) begin
            chk("ar_get_expected", aq.size() != 0, 1);
            if (aq.size() != 0) begin
                logic [32:0] e;
                e = aq.pop_front();
                chk("ar_get_owner", {ifc.m1_ar_get, ifc.m0_ar_get}, e[32] ? 2'b10 : 2'b01);
                chk("s_ar_addr", ifc.s_ar_addr, e[31:0]);
            end
        end
        if (ifc.m0_r_valid && ifc.m0_r_ready) begin
            chk("m0_beat_expected", q0.size() != 0, 1);
            if (q0.size() != 0) chk("m0_beat", {ifc.m0_r_end, ifc.m0_r_data}, q0.pop_front());
        end
        if (ifc.m1_r_valid && ifc.m1_r_ready) begin
            chk("m1_beat_expected", q1.size() != 0, 1);
            if (q1.size() != 0) chk("m1_beat", {ifc.m1_r_end, ifc.m1_r_data}, q1.pop_front());
        end
    end

    // acts as the shared read port for one burst; called with the DUT idle and requests already driven
    task automatic serve(input int agd, input int nb, input int st_at, input int st_len,
                         input bit stray, input bit clr);
        logic o, e;
        o = (ifc.m0_ar_en && ifc.m1_ar_en) ? ~m_last : ifc.m1_ar_en;
        aq.push_back({o, o ? ifc.m1_ar_addr : ifc.m0_ar_addr});
        step();
        chk("s_ar_en_rise", ifc.s_ar_en, 1);
        chk("grant", grant, o ? 2'b10 : 2'b01);
        repeat (agd) begin
            ifc.s_r_valid = stray;
            ifc.s_r_end = stray;
            #1;
            if (stray) begin
                chk("stray_addr_ready", ifc.s_r_ready, 0);
                chk("stray_addr_valid", {ifc.m1_r_valid, ifc.m0_r_valid}, 0);
            end
            step();
        end
        ifc.s_r_valid = 1'b0;
        ifc.s_r_end = 1'b0;
        ifc.s_ar_get = 1'b1;
        step();
        ifc.s_ar_get = 1'b0;
        chk("s_ar_en_fall", ifc.s_ar_en, 0);
        if (o) begin ifc.m1_ar_en = 1'b0; rem1--; end
        else begin ifc.m0_ar_en = 1'b0; rem0--; end
        for (int b = 0; b < nb; b++) begin
            d = {$urandom, $urandom};
            e = (b == nb - 1);
            if (o) q1.push_back({e, d});
            else q0.push_back({e, d});
            ifc.s_r_valid = 1'b1;
            ifc.s_r_data = d;
            ifc.s_r_end = e;
            cnt_clr = clr & e;
            if (b == st_at) begin
                ifc.m0_r_ready = 1'b0;
                ifc.m1_r_ready = 1'b0;
                repeat (st_len) begin
                    #1 chk("stall_ready", ifc.s_r_ready, 0);
                    step();
                end
                ifc.m0_r_ready = 1'b1;
                ifc.m1_r_ready = 1'b1;
            end
            #1;
            chk("s_r_ready", ifc.s_r_ready, 1);
            chk("other_no_valid", o ? ifc.m0_r_valid : ifc.m1_r_valid, 0);
            step();
        end
        ifc.s_r_valid = 1'b0;
        ifc.s_r_end = 1'b0;
        cnt_clr = 1'b0;
        if (clr) begin c0 = '0; c1 = '0; end
        else if (o) c1 = c1 + 1'b1;
        else c0 = c0 + 1'b1;
        m_last = o;
        chk("m0_burst_cnt", m0_burst_cnt, c0);
        chk("m1_burst_cnt", m1_burst_cnt, c1);
        chk("idle_grant", grant, 0);
        chk("idle_busy", busy, 0);
        if (!o && rem0 > 0) begin ifc.m0_ar_addr += 32'h100; ifc.m0_ar_en = 1'b1; end
        if (o && rem1 > 0) begin ifc.m1_ar_addr += 32'h100; ifc.m1_ar_en = 1'b1; end
    endtask

    initial begin
        {ifc.m0_ar_en, ifc.m1_ar_en, ifc.s_ar_get, ifc.s_r_valid, ifc.s_r_end} = '0;
        {ifc.m0_ar_addr, ifc.m1_ar_addr, ifc.s_r_data} = '0;
        ifc.m0_r_ready = 1'b1;
        ifc.m1_r_ready = 1'b1;
        step();
        step();
        chk("rst_s_ar_en", ifc.s_ar_en, 0);
        chk("rst_s_ar_addr", ifc.s_ar_addr, 0);
        chk("rst_grant_busy", {grant, busy}, 0);
        chk("rst_cnts", {m1_burst_cnt, m0_burst_cnt}, 0);
        chk("rst_comb", {ifc.s_r_ready, ifc.m0_r_valid, ifc.m1_r_valid, ifc.m0_ar_get, ifc.m1_ar_get}, 0);
        rstn = 1'b1;
        step();
        // single m0 burst
        ifc.m0_ar_addr = 32'h1000_0000;
        ifc.m0_ar_en = 1'b1;
        rem0 = 1;
        serve(3, 4, -1, 0, 0, 0);
        // stray beats while idle, then during an m1 address phase
        ifc.s_r_valid = 1'b1;
        ifc.s_r_end = 1'b1;
        step();
        chk("stray_idle_ready", ifc.s_r_ready, 0);
        chk("stray_idle_valid", {ifc.m1_r_valid, ifc.m0_r_valid}, 0);
        step();
        chk("stray_idle_cnts", {m1_burst_cnt, m0_burst_cnt}, {c1, c0});
        ifc.m1_ar_addr = 32'h2000_0040;
        ifc.m1_ar_en = 1'b1;
        rem1 = 1;
        serve(3, 2, -1, 0, 1, 0);
        // simultaneous requests, three rounds each
        ifc.m0_ar_addr = 32'h3000_0000;
        ifc.m1_ar_addr = 32'h4000_0000;
        rem0 = 3;
        rem1 = 3;
        ifc.m0_ar_en = 1'b1;
        ifc.m1_ar_en = 1'b1;
        for (int r = 0; r < 6; r++) serve(1, 2, -1, 0, 0, 0);
        // requester back-pressure mid-burst
        ifc.m0_ar_addr = 32'h5000_0000;
        ifc.m0_ar_en = 1'b1;
        rem0 = 1;
        serve(0, 6, 2, 5, 0, 0);
        // clear coinciding with a burst completing at the counter maximum
        while (c0 != '1) begin
            ifc.m0_ar_en = 1'b1;
            rem0 = 1;
            serve(0, 1, -1, 0, 0, 0);
        end
        ifc.m0_ar_en = 1'b1;
        rem0 = 1;
        serve(0, 1, -1, 0, 0, 1);
        // wrap at the counter maximum
        while (c0 != '1) begin
            ifc.m0_ar_en = 1'b1;
            rem0 = 1;
            serve(0, 1, -1, 0, 0, 0);
        end
        ifc.m0_ar_en = 1'b1;
        rem0 = 1;
        serve(0, 1, -1, 0, 0, 0);
        // asynchronous reset during beat 2 of an 8-beat m0 burst
        ifc.m0_ar_addr = 32'h6000_0000;
        ifc.m0_ar_en = 1'b1;
        aq.push_back({1'b0, 32'h6000_0000});
        step();
        ifc.s_ar_get = 1'b1;
        step();
        ifc.s_ar_get = 1'b0;
        ifc.m0_ar_en = 1'b0;
        for (int b = 0; b < 2; b++) begin
            d = {$urandom, $urandom};
            q0.push_back({1'b0, d});
            ifc.s_r_valid = 1'b1;
            ifc.s_r_data = d;
            step();
        end
        rstn = 1'b0;
        ifc.s_r_data = 64'hdead_beef_0000_0002;
        #1;
        chk("arst_s_ar", {ifc.s_ar_en, ifc.s_ar_addr}, 0);
        chk("arst_grant_busy", {grant, busy}, 0);
        chk("arst_r", {ifc.s_r_ready, ifc.m0_r_valid, ifc.m0_r_end, ifc.m0_r_data}, 0);
        chk("arst_cnts", {m1_burst_cnt, m0_burst_cnt}, 0);
        chk("arst_beats_drained", q0.size(), 0);
        step();
        ifc.s_r_valid = 1'b0;
        step();
        rstn = 1'b1;
        m_last = 1'b1;
        c0 = '0;
        c1 = '0;
        ifc.m1_ar_addr = 32'h7000_0000;
        ifc.m1_ar_en = 1'b1;
        rem1 = 1;
        serve(1, 3, -1, 0, 0, 0);
        step();
        chk("aq_empty", aq.size(), 0);
        chk("q_empty", q0.size() + q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
